// File: rtl/ysyx_24110006_exu_pkg.sv
// Constants shared by decode and execute: datapath width and ALU op codes.
// Low three bits of a branch code follow RISC-V funct3; bit 3 marks compare ops.
package ysyx_24110006_exu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SR   = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [3:0] ALU_BEQ  = 4'b1000;
    localparam logic [3:0] ALU_BNE  = 4'b1001;
    localparam logic [3:0] ALU_BLT  = 4'b1100;
    localparam logic [3:0] ALU_BGE  = 4'b1101;
    localparam logic [3:0] ALU_BLTU = 4'b1110;
    localparam logic [3:0] ALU_BGEU = 4'b1111;

endpackage

// File: rtl/ysyx_24110006_exu_alu.sv
// Combinational ALU: adder/subtractor, shifts, logic ops, plus eq/lt flags.
// Signedness of every comparison (SLT/SLTU and branches) is chosen by sign.
module ysyx_24110006_exu_alu
    import ysyx_24110006_exu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_t,
    input  logic            sub,
    input  logic            sign,
    input  logic            sra,
    output logic [XLEN-1:0] result,
    output logic            eq,
    output logic            lt
);

    logic [XLEN-1:0] b_eff;
    logic [XLEN-1:0] sum;
    logic [4:0]      shamt;

    assign b_eff = sub ? ~b : b;
    assign sum   = a + b_eff + XLEN'(sub);
    assign shamt = b[4:0];
    assign eq    = (a == b);
    assign lt    = sign ? ($signed(a) < $signed(b)) : (a < b);

    always_comb begin
        result = sum;
        case (alu_t)
            ALU_ADD:  result = sum;
            ALU_SLL:  result = a << shamt;
            ALU_SLT,
            ALU_SLTU: result = XLEN'(lt);
            ALU_XOR:  result = a ^ b;
            ALU_SR:   result = sra ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = sum;
        endcase
    end

endmodule

// File: rtl/ysyx_24110006_exu.sv
// Execute stage: one registered output entry, branch/jump resolution and a
// single-cycle fetch redirect pulse per accepted bundle.
module ysyx_24110006_exu #(
    parameter int XLEN = ysyx_24110006_exu_pkg::XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_imm,
    input  logic [3:0]      i_alu_t,
    input  logic            i_sub,
    input  logic            i_sign,
    input  logic            i_alu_sra,
    input  logic            i_a_pc,
    input  logic            i_b_imm,
    input  logic            i_br,
    input  logic            i_jal,
    input  logic            i_jalr,
    input  logic [4:0]      i_rd,
    input  logic            i_wen,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd,
    output logic            o_wen,
    output logic [XLEN-1:0] o_store_data,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc
);

    import ysyx_24110006_exu_pkg::*;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Upstream: accept = i_valid && o_ready; o_ready stays high while draining.
    // Downstream: the entry leaves when o_valid && i_ready; while stalled every
    // output holds, except o_redirect which pulses only in its first cycle.

    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic            alu_eq, alu_lt;
    logic            br_taken;
    logic [XLEN-1:0] pc_target, jalr_sum, jalr_target, link_addr;
    logic [XLEN-1:0] next_result, next_redirect_pc;
    logic            next_redirect, next_wen;
    logic            accept;

    assign alu_a = i_a_pc  ? i_pc  : i_rs1;
    assign alu_b = i_b_imm ? i_imm : i_rs2;

    ysyx_24110006_exu_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .alu_t  (i_alu_t),
        .sub    (i_sub),
        .sign   (i_sign),
        .sra    (i_alu_sra),
        .result (alu_result),
        .eq     (alu_eq),
        .lt     (alu_lt)
    );

    always_comb begin
        br_taken = 1'b0;
        case (i_alu_t)
            ALU_BEQ:           br_taken = alu_eq;
            ALU_BNE:           br_taken = !alu_eq;
            ALU_BLT, ALU_BLTU: br_taken = alu_lt;
            ALU_BGE, ALU_BGEU: br_taken = !alu_lt;
            default:           br_taken = 1'b0;
        endcase
    end

    assign pc_target   = i_pc + i_imm;
    assign jalr_sum    = i_rs1 + i_imm;
    assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};
    assign link_addr   = i_pc + XLEN'(4);

    always_comb begin
        next_redirect    = i_jal || i_jalr || (i_br && br_taken);
        next_redirect_pc = '0;
        if (next_redirect) begin
            next_redirect_pc = i_jalr ? jalr_target : pc_target;
        end
        next_result = (i_jal || i_jalr) ? link_addr : alu_result;
        next_wen    = i_wen && (i_rd != 5'd0) && !i_br;
    end

    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            o_valid       <= 1'b0;
            o_redirect    <= 1'b0;
            o_wen         <= 1'b0;
            o_result      <= '0;
            o_rd          <= '0;
            o_store_data  <= '0;
            o_redirect_pc <= '0;
        end else if (accept) begin
            o_valid       <= 1'b1;
            o_redirect    <= next_redirect;
            o_wen         <= next_wen;
            o_result      <= next_result;
            o_rd          <= i_rd;
            o_store_data  <= i_rs2;
            o_redirect_pc <= next_redirect_pc;
        end else begin
            o_redirect <= 1'b0;
            if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
